framed_seq_detect: RTL and testbench

Parametrised serial pattern detector for single-bit input streams with a valid qualifier. It compares either consecutive non-overlapping frames or a sliding window against a run-time pattern and mask. It emits registered match/not_match pulses and keeps a saturating hit counter. It sits after bit-serial capture logic and replaces fixed 6-bit frame detectors in the sequence-detection family.

---
 rtl/framed_seq_detect.sv | 103 ++++++++++
 tb/tb_framed_seq_detect.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/framed_seq_detect.sv
// Serial pattern detector: framed (non-overlapping) or sliding-window compare against a masked pattern.
// Latency: match/not_match register one cycle after the completing bit; no backpressure, data_valid=0 stalls.
module framed_seq_detect #(
    parameter int FRAME_LEN = 6,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 mode,
    input  logic                 data_valid,
    input  logic                 data,
    input  logic [FRAME_LEN-1:0] pattern,
    input  logic [FRAME_LEN-1:0] mask,
    output logic                 match,
    output logic                 not_match,
    output logic [CNT_W-1:0]     hit_cnt
);

    localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] sr, sr_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 full, full_nxt;
    logic                 mode_q;
    logic                 match_nxt, not_match_nxt;
    logic [CNT_W-1:0]     hit_cnt_nxt;

    logic [FRAME_LEN-1:0] word;
    logic                 hit;
    logic                 last;

    // Candidate word includes the bit arriving this cycle, so a compare needs no extra cycle.
    assign word = {sr[FRAME_LEN-2:0], data};
    assign hit  = ((word ^ pattern) & mask) == '0;
    assign last = (cnt == LAST);

    always_comb begin
        sr_nxt        = sr;
        cnt_nxt       = cnt;
        full_nxt      = full;
        match_nxt     = 1'b0;
        not_match_nxt = 1'b0;
        hit_cnt_nxt   = hit_cnt;

        if (clear) begin
            sr_nxt      = '0;
            cnt_nxt     = '0;
            full_nxt    = 1'b0;
            hit_cnt_nxt = '0;
        end else if (mode != mode_q) begin
            // Switching mode restarts alignment; the bit presented now is dropped.
            sr_nxt   = '0;
            cnt_nxt  = '0;
            full_nxt = 1'b0;
        end else if (data_valid) begin
            sr_nxt = word;
            if (!mode_q) begin
                if (last) begin
                    cnt_nxt       = '0;
                    match_nxt     = hit;
                    not_match_nxt = !hit;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                if (last) begin
                    full_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (full || last) begin
                    match_nxt = hit;
                end
            end
            if (match_nxt && (hit_cnt != '1)) begin
                hit_cnt_nxt = hit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            full      <= 1'b0;
            mode_q    <= 1'b0;
            match     <= 1'b0;
            not_match <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            full      <= full_nxt;
            mode_q    <= mode;
            match     <= match_nxt;
            not_match <= not_match_nxt;
            hit_cnt   <= hit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_framed_seq_detect.sv
// Directed bench for framed_seq_detect (FRAME_LEN=6, CNT_W=2 so saturation is reachable).
module tb_framed_seq_detect;

    localparam int FL = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          mode = 1'b0;
    logic          data_valid = 1'b0;
    logic          data = 1'b0;
    logic [FL-1:0] pattern = '0;
    logic [FL-1:0] mask = '1;
    logic          match;
    logic          not_match;
    logic [CW-1:0] hit_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    framed_seq_detect #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .mode       (mode),
        .data_valid (data_valid),
        .data       (data),
        .pattern    (pattern),
        .mask       (mask),
        .match      (match),
        .not_match  (not_match),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic em, input logic enm, input int eh);
        check({tag, ".match"}, 32'(match), 32'(em));
        check({tag, ".not_match"}, 32'(not_match), 32'(enm));
        check({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(eh));
    endtask

    // Present one input cycle, then sample one time unit after the edge.
    task automatic step(input logic v, input logic d, input logic em, input logic enm,
                        input int eh, input string tag);
        data_valid = v;
        data       = d;
        @(posedge clk);
        #1;
        check_out(tag, em, enm, eh);
    endtask

    // Send a 6-bit frame MSB first; only the last bit may produce an output.
    task automatic send_frame(input logic [FL-1:0] bits, input logic lm, input logic lnm,
                              input int h0, input int h1, input logic stalls, input string tag);
        for (int i = FL - 1; i >= 0; i--) begin
            if (i == 0) step(1'b1, bits[i], lm, lnm, h1, tag);
            else        step(1'b1, bits[i], 1'b0, 1'b0, h0, tag);
            if (stalls) step(1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? h1 : h0, {tag, ".stall"});
        end
    endtask

    initial begin
        logic [9:0] slide_bits;
        int         eh;
        slide_bits = 10'b1010101010;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        // Framed: one matching frame then one mismatching frame, back to back.
        pattern = 6'b011100;
        mask    = 6'h3F;
        send_frame(6'b011100, 1'b1, 1'b0, 0, 1, 1'b0, "framed_hit");
        send_frame(6'b011101, 1'b0, 1'b1, 1, 1, 1'b0, "framed_miss");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "framed_idle");

        // Masked LSB with a stall after every bit.
        mask = 6'b111110;
        send_frame(6'b011101, 1'b1, 1'b0, 1, 2, 1'b1, "masked_stall");

        // Clear combined with a mode change to sliding; the presented bit is dropped.
        clear = 1'b1;
        mode  = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "clear_to_slide");
        clear   = 1'b0;
        pattern = 6'b101010;
        mask    = 6'h3F;
        eh = 0;
        for (int i = 9; i >= 0; i--) begin
            // Windows ending on bits 6, 8, 10 equal 101010.
            if (i == 4 || i == 2 || i == 0) begin
                eh++;
                step(1'b1, slide_bits[i], 1'b1, 1'b0, eh, "slide_hit");
            end else begin
                step(1'b1, slide_bits[i], 1'b0, 1'b0, eh, "slide_nohit");
            end
        end
        check("slide_total", 32'(hit_cnt), 32'd3);

        // Back to framed via clear, three bits, then a mode change mid-frame.
        clear = 1'b1;
        mode  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "clear_to_framed");
        clear   = 1'b0;
        pattern = 6'b011100;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, "mid_frame");
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "mid_frame");
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "mid_frame");
        mode = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "mode_change_drop");
        send_frame(6'b011100, 1'b1, 1'b0, 0, 1, 1'b0, "after_mode_change");

        // Saturation: five matching frames with a 2-bit counter.
        clear = 1'b1;
        mode  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "clear_sat");
        clear = 1'b0;
        send_frame(6'b011100, 1'b1, 1'b0, 0, 1, 1'b0, "sat1");
        send_frame(6'b011100, 1'b1, 1'b0, 1, 2, 1'b0, "sat2");
        send_frame(6'b011100, 1'b1, 1'b0, 2, 3, 1'b0, "sat3");
        send_frame(6'b011100, 1'b1, 1'b0, 3, 3, 1'b0, "sat4");
        send_frame(6'b011100, 1'b1, 1'b0, 3, 3, 1'b0, "sat5");

        // Partial frame, then clear with valid data: realignment on the next bit.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3, "partial");
        step(1'b1, 1'b1, 1'b0, 1'b0, 3, "partial");
        clear = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, "clear_with_valid");
        clear = 1'b0;
        send_frame(6'b011100, 1'b1, 1'b0, 0, 1, 1'b0, "after_clear");

        // Asynchronous reset after four bits of a frame.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1, "pre_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, "pre_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, "pre_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, "pre_reset");
        data_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(6'b011100, 1'b1, 1'b0, 0, 1, 1'b0, "after_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
